// File: rtl/param_rx_responder.sv
// MBINIT.PARAM partner side: waits for the remote configuration request,
// negotiates it against local capabilities and returns the response.
module param_rx_responder #(
   parameter int SB_MSG_Width   = 4,
   parameter int PARAM_W        = 16,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                    i_clk,
   input  logic                    i_rst,
   input  logic                    i_MBINIT_en,
   input  logic                    i_sb_busy,
   input  logic                    i_falling_edge_busy,
   input  logic                    i_sb_valid,
   input  logic [SB_MSG_Width-1:0] i_decoded_sb_msg,
   input  logic [PARAM_W-1:0]      i_rx_param_data,
   input  logic [PARAM_W-1:0]      i_local_param,
   output logic [SB_MSG_Width-1:0] o_encoded_SB_msg,
   output logic                    o_msg_valid,
   output logic [PARAM_W-1:0]      o_tx_param_data,
   output logic                    o_PARAM_RX_end,
   output logic                    o_error_req
);

   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
   localparam logic [SB_MSG_Width-1:0] MSG_REQ  = SB_MSG_Width'(1);
   localparam logic [SB_MSG_Width-1:0] MSG_RESP = SB_MSG_Width'(2);

   typedef enum logic [2:0] {
      IDLE,
      WAIT_REQ,
      NEGOTIATE,
      SEND_RESP,
      DONE,
      ERROR
   } state_t;

   state_t             state;
   logic [CNT_W-1:0]   tmo_cnt;
   logic [PARAM_W-1:0] remote_q;
   logic [PARAM_W-1:0] neg_w;
   logic [3:0]         rate_w;
   logic               req_hit;
   logic               unused_bits;

   assign req_hit = i_sb_valid && (i_decoded_sb_msg == MSG_REQ);
   assign rate_w  = (remote_q[3:0] < i_local_param[3:0]) ?
                    remote_q[3:0] : i_local_param[3:0];

   // Remote only contributes capability bits; IDs and swing are ours.
   always_comb begin
      neg_w        = '0;
      neg_w[3:0]   = rate_w;
      neg_w[4]     = remote_q[4] & i_local_param[4];
      neg_w[5]     = remote_q[5] & i_local_param[5];
      neg_w[7:6]   = i_local_param[7:6];
      neg_w[8]     = remote_q[8] & i_local_param[8];
      neg_w[13:9]  = i_local_param[13:9];
   end

   assign unused_bits = ^{remote_q[15:9], remote_q[7:6],
                          i_local_param[15:14]};

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state            <= IDLE;
         tmo_cnt          <= '0;
         remote_q         <= '0;
         o_encoded_SB_msg <= '0;
         o_msg_valid      <= 1'b0;
         o_tx_param_data  <= '0;
         o_PARAM_RX_end   <= 1'b0;
         o_error_req      <= 1'b0;
      end else if (!i_MBINIT_en) begin
         state            <= IDLE;
         tmo_cnt          <= '0;
         o_encoded_SB_msg <= '0;
         o_msg_valid      <= 1'b0;
         o_tx_param_data  <= '0;
         o_PARAM_RX_end   <= 1'b0;
         o_error_req      <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               tmo_cnt <= '0;
               state   <= WAIT_REQ;
            end
            WAIT_REQ: begin
               // A request in the terminal-count cycle beats the timeout.
               if (req_hit) begin
                  remote_q <= i_rx_param_data;
                  tmo_cnt  <= '0;
                  state    <= NEGOTIATE;
               end else if (tmo_cnt == TMO_LAST) begin
                  tmo_cnt     <= '0;
                  o_error_req <= 1'b1;
                  state       <= ERROR;
               end else begin
                  tmo_cnt <= tmo_cnt + CNT_W'(1);
               end
            end
            NEGOTIATE: begin
               tmo_cnt <= '0;
               if (rate_w == 4'd0) begin
                  o_error_req <= 1'b1;
                  state       <= ERROR;
               end else if (!i_sb_busy) begin
                  o_msg_valid      <= 1'b1;
                  o_encoded_SB_msg <= MSG_RESP;
                  o_tx_param_data  <= neg_w;
                  state            <= SEND_RESP;
               end
            end
            SEND_RESP: begin
               tmo_cnt <= '0;
               if (i_falling_edge_busy) begin
                  o_msg_valid      <= 1'b0;
                  o_encoded_SB_msg <= '0;
                  o_PARAM_RX_end   <= 1'b1;
                  state            <= DONE;
               end
            end
            DONE: begin
               tmo_cnt <= '0;
            end
            ERROR: begin
               tmo_cnt <= '0;
            end
            default: begin
               tmo_cnt <= '0;
               state   <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_param_rx_responder.sv
// Bench for param_rx_responder: vector table, corner sequences and
// randomized transactions against a field-level negotiation model.
module tb_param_rx_responder;

   localparam int TMO = 8;

   logic        i_clk = 1'b0;
   logic        i_rst;
   logic        i_MBINIT_en;
   logic        i_sb_busy;
   logic        i_falling_edge_busy;
   logic        i_sb_valid;
   logic [3:0]  i_decoded_sb_msg;
   logic [15:0] i_rx_param_data;
   logic [15:0] i_local_param;
   logic [3:0]  o_encoded_SB_msg;
   logic        o_msg_valid;
   logic [15:0] o_tx_param_data;
   logic        o_PARAM_RX_end;
   logic        o_error_req;

   int total = 0;
   int bad   = 0;

   param_rx_responder #(
      .SB_MSG_Width  (4),
      .PARAM_W       (16),
      .TIMEOUT_CYCLES(TMO)
   ) dut (
      .i_clk              (i_clk),
      .i_rst              (i_rst),
      .i_MBINIT_en        (i_MBINIT_en),
      .i_sb_busy          (i_sb_busy),
      .i_falling_edge_busy(i_falling_edge_busy),
      .i_sb_valid         (i_sb_valid),
      .i_decoded_sb_msg   (i_decoded_sb_msg),
      .i_rx_param_data    (i_rx_param_data),
      .i_local_param      (i_local_param),
      .o_encoded_SB_msg   (o_encoded_SB_msg),
      .o_msg_valid        (o_msg_valid),
      .o_tx_param_data    (o_tx_param_data),
      .o_PARAM_RX_end     (o_PARAM_RX_end),
      .o_error_req        (o_error_req)
   );

   always #5 i_clk = ~i_clk;

   typedef struct {
      logic [15:0] remote;
      logic [15:0] loc;
      int          busy;
      logic        err;
      logic [15:0] pay;
   } vec_t;

   vec_t vecs[8];

   function automatic logic [22:0] pack(logic v, logic [3:0] m,
                                        logic [15:0] d, logic e,
                                        logic er);
      return {v, m, d, e, er};
   endfunction

   function automatic logic [22:0] outs();
      return {o_msg_valid, o_encoded_SB_msg, o_tx_param_data,
              o_PARAM_RX_end, o_error_req};
   endfunction

   // Field-by-field negotiation, returned as {error, payload}.
   function automatic logic [16:0] model_neg(logic [15:0] r,
                                             logic [15:0] l);
      int ri, li, rate, mode, phase, mid, x32, sw, p;
      ri    = int'(r);
      li    = int'(l);
      rate  = ((ri % 16) < (li % 16)) ? (ri % 16) : (li % 16);
      mode  = ((ri / 16) % 2) * ((li / 16) % 2);
      phase = ((ri / 32) % 2) * ((li / 32) % 2);
      mid   = (li / 64) % 4;
      x32   = ((ri / 256) % 2) * ((li / 256) % 2);
      sw    = (li / 512) % 32;
      p     = rate + 16 * mode + 32 * phase + 64 * mid
              + 256 * x32 + 512 * sw;
      return {rate == 0, 16'(p)};
   endfunction

   task automatic chk(input string nm, input logic [22:0] exp);
      total++;
      if (outs() !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", nm, outs(), exp);
      end
   endtask

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   task automatic restart();
      i_MBINIT_en = 1'b0;
      tick();
      i_MBINIT_en = 1'b1;
      tick();
   endtask

   task automatic send(input logic [3:0] id, input logic [15:0] d);
      i_sb_valid       = 1'b1;
      i_decoded_sb_msg = id;
      i_rx_param_data  = d;
      tick();
      i_sb_valid       = 1'b0;
      i_decoded_sb_msg = 4'd0;
      i_rx_param_data  = 16'd0;
   endtask

   // Issue a request from WAIT_REQ and follow it to DONE or ERROR.
   task automatic run_txn(input logic [15:0] rem, input logic [15:0] loc,
                          input int b, input logic [15:0] pay,
                          input logic err, input string nm);
      i_local_param = loc;
      i_sb_busy     = (b > 0);
      send(4'd1, rem);
      chk({nm, "/neg"}, pack(1'b0, 4'd0, 16'd0, 1'b0, 1'b0));
      if (err) begin
         tick();
         chk({nm, "/err"}, pack(1'b0, 4'd0, 16'd0, 1'b0, 1'b1));
         tick();
         chk({nm, "/sticky"}, pack(1'b0, 4'd0, 16'd0, 1'b0, 1'b1));
         i_sb_busy = 1'b0;
      end else begin
         for (int k = 0; k < b; k++) begin
            tick();
            chk({nm, "/busy"}, pack(1'b0, 4'd0, 16'd0, 1'b0, 1'b0));
         end
         i_sb_busy = 1'b0;
         tick();
         chk({nm, "/resp"}, pack(1'b1, 4'd2, pay, 1'b0, 1'b0));
         tick();
         chk({nm, "/hold"}, pack(1'b1, 4'd2, pay, 1'b0, 1'b0));
         i_falling_edge_busy = 1'b1;
         tick();
         i_falling_edge_busy = 1'b0;
         chk({nm, "/done"}, pack(1'b0, 4'd0, pay, 1'b1, 1'b0));
      end
   endtask

   initial begin
      logic [16:0] m;
      logic [15:0] rr, ll;
      logic [3:0]  jid;
      int          w, b;

      vecs[0] = '{16'h0213, 16'h01F5, 0, 1'b0, 16'h00D3};
      vecs[1] = '{16'h0000, 16'h01F5, 0, 1'b1, 16'h0000};
      vecs[2] = '{16'hFFFF, 16'hFFFF, 1, 1'b0, 16'h3FFF};
      vecs[3] = '{16'hFFF0, 16'hFFFF, 2, 1'b1, 16'h0000};
      vecs[4] = '{16'h0107, 16'h3E0A, 5, 1'b0, 16'h3E07};
      vecs[5] = '{16'h0139, 16'h4171, 0, 1'b0, 16'h0171};
      vecs[6] = '{16'h0002, 16'h0000, 0, 1'b1, 16'h0000};
      vecs[7] = '{16'h0008, 16'h8088, 3, 1'b0, 16'h0088};

      i_rst = 1'b1;
      i_MBINIT_en = 1'b0;
      i_sb_busy = 1'b0;
      i_falling_edge_busy = 1'b0;
      i_sb_valid = 1'b0;
      i_decoded_sb_msg = 4'd0;
      i_rx_param_data = 16'd0;
      i_local_param = 16'd0;
      tick();
      tick();
      chk("reset", pack(1'b0, 4'd0, 16'd0, 1'b0, 1'b0));
      i_rst = 1'b0;

      foreach (vecs[i]) begin
         restart();
         run_txn(vecs[i].remote, vecs[i].loc, vecs[i].busy,
                 vecs[i].pay, vecs[i].err, $sformatf("vec%0d", i));
      end
      i_MBINIT_en = 1'b0;
      tick();
      chk("en_drop_clears_err", pack(1'b0, 4'd0, 16'd0, 1'b0, 1'b0));

      // Timeout with no request.
      restart();
      for (int k = 1; k < TMO; k++) begin
         tick();
         chk($sformatf("tmo_wait%0d", k),
             pack(1'b0, 4'd0, 16'd0, 1'b0, 1'b0));
      end
      tick();
      chk("tmo_err", pack(1'b0, 4'd0, 16'd0, 1'b0, 1'b1));

      // Request in the terminal-count cycle wins.
      restart();
      for (int k = 1; k < TMO; k++) tick();
      i_local_param = 16'h000F;
      send(4'd1, 16'h0003);
      chk("tmo_last_neg", pack(1'b0, 4'd0, 16'd0, 1'b0, 1'b0));
      tick();
      chk("tmo_last_resp", pack(1'b1, 4'd2, 16'h0003, 1'b0, 1'b0));

      // A response ID seen in WAIT_REQ is ignored.
      restart();
      i_local_param = 16'h01F5;
      send(4'd2, 16'h0213);
      chk("filt_resp_id", pack(1'b0, 4'd0, 16'd0, 1'b0, 1'b0));
      tick();
      chk("filt_after", pack(1'b0, 4'd0, 16'd0, 1'b0, 1'b0));
      run_txn(16'h0213, 16'h01F5, 0, 16'h00D3, 1'b0, "filt_txn");

      // Enable dropped mid-response, then restart.
      restart();
      send(4'd1, 16'h0213);
      tick();
      chk("abort_resp", pack(1'b1, 4'd2, 16'h00D3, 1'b0, 1'b0));
      i_MBINIT_en = 1'b0;
      tick();
      chk("abort_off", pack(1'b0, 4'd0, 16'd0, 1'b0, 1'b0));
      i_MBINIT_en = 1'b1;
      tick();
      run_txn(16'hFFFF, 16'hFFFF, 0, 16'h3FFF, 1'b0, "abort_re");

      // DONE ignores further requests; reset returns to IDLE.
      send(4'd1, 16'h0001);
      chk("done_ign_req", pack(1'b0, 4'd0, 16'h3FFF, 1'b1, 1'b0));
      i_rst = 1'b1;
      tick();
      chk("rst_in_done", pack(1'b0, 4'd0, 16'd0, 1'b0, 1'b0));
      i_rst = 1'b0;
      i_local_param = 16'h01F5;
      send(4'd1, 16'h0213);
      chk("idle_req_drop", pack(1'b0, 4'd0, 16'd0, 1'b0, 1'b0));
      tick();
      chk("idle_req_lost", pack(1'b0, 4'd0, 16'd0, 1'b0, 1'b0));
      run_txn(16'h0213, 16'h01F5, 0, 16'h00D3, 1'b0, "post_rst");

      // Randomized transactions with junk traffic before the request.
      for (int it = 0; it < 40; it++) begin
         restart();
         w = $urandom_range(0, 6);
         for (int k = 0; k < w; k++) begin
            if ($urandom_range(0, 1) == 1) begin
               jid = 4'($urandom_range(2, 15));
               if ($urandom_range(0, 3) == 0) jid = 4'd0;
               send(jid, 16'($urandom));
            end else begin
               tick();
            end
         end
         chk($sformatf("rnd%0d/wait", it),
             pack(1'b0, 4'd0, 16'd0, 1'b0, 1'b0));
         rr = 16'($urandom);
         ll = 16'($urandom);
         b  = $urandom_range(0, 3);
         m  = model_neg(rr, ll);
         run_txn(rr, ll, b, m[15:0], m[16], $sformatf("rnd%0d", it));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
